// File: rtl/ipd_stage_pkg.sv
// Shared widths, LA32R opcode fields and predecode helper for ipd_stage.
// Macro IPD_PREDECODE_EN widens the IPD->ID bus from 96 to 100 bits.
package ipd_stage_pkg;

  localparam int IF_TO_IPD_BUS_WD = 96;
`ifdef IPD_PREDECODE_EN
  localparam int IPD_TO_ID_BUS_WD = 100;
`else
  localparam int IPD_TO_ID_BUS_WD = 96;
`endif

  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BGEU = 6'b011011;

  typedef struct packed {
    logic is_jirl;
    logic is_b_bl;
    logic is_cond_br;
    logic is_bl;
  } predec_t;

  function automatic predec_t predecode(input logic [31:0] inst);
    predec_t    pd;
    logic [5:0] op;
    op            = inst[31:26];
    pd.is_jirl    = (op == OP_JIRL);
    pd.is_b_bl    = (op == OP_B) || (op == OP_BL);
    pd.is_cond_br = (op >= OP_BEQ) && (op <= OP_BGEU);
    pd.is_bl      = (op == OP_BL);
    return pd;
  endfunction

endpackage

// File: rtl/ipd_inst_hold.sv
// Holds the RAM read word once an entry stalls; selects RAM vs buffer.
// Ports: clk, reset, capture, depart, flush, valid, rdata -> inst.
module ipd_inst_hold
  import ipd_stage_pkg::*;
#(
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        depart,
  input  logic        flush,
  input  logic        valid,
  input  logic [31:0] rdata,
  output logic [31:0] inst
);

  logic        hold_valid_q, hold_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  always_comb begin
    hold_valid_d = hold_valid_q;
    inst_buf_d   = inst_buf_q;
    if (capture) begin
      hold_valid_d = 1'b0;
    end else if (flush || depart) begin
      hold_valid_d = 1'b0;
    end else if (valid && !hold_valid_q) begin
      // RAM data is only valid for one cycle; keep it for the stall.
      hold_valid_d = 1'b1;
      inst_buf_d   = rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      inst_buf_q   <= RESET_INST;
    end else begin
      hold_valid_q <= hold_valid_d;
      inst_buf_q   <= inst_buf_d;
    end
  end

  assign inst = hold_valid_q ? inst_buf_q : rdata;

endmodule

// File: rtl/ipd_stage.sv
// Instruction pre-decode stage between IF and ID: {pred_PC, PC, inst}.
// Ports: IF bus/valid in, allow_in out, RAM rdata, ID flush, ID bus out.
module ipd_stage
  import ipd_stage_pkg::*;
#(
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
  input  logic                        IF_to_IPD_valid,
  output logic                        IPD_allow_in,
  input  logic [31:0]                 inst_ram_rdata,
  input  logic                        ID_flush,
  output logic [IPD_TO_ID_BUS_WD-1:0] IPD_to_ID_bus,
  output logic                        IPD_to_ID_valid,
  input  logic                        ID_allow_in
);

  logic        ipd_valid_q, ipd_valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pred_pc_q, pred_pc_d;
  logic        ipd_ready_go;
  logic        capture;
  logic        depart;
  logic [31:0] inst;

  assign ipd_ready_go = 1'b1;
  assign IPD_allow_in = ~ipd_valid_q
                      | (ipd_ready_go & ID_allow_in)
                      | ID_flush;
  assign capture = IF_to_IPD_valid & IPD_allow_in;
  assign depart  = ipd_valid_q & ipd_ready_go & ID_allow_in;

  always_comb begin
    ipd_valid_d = ipd_valid_q;
    pc_d        = pc_q;
    pred_pc_d   = pred_pc_q;
    if (capture) begin
      ipd_valid_d = 1'b1;
      pc_d        = IF_to_IPD_bus[63:32];
      pred_pc_d   = IF_to_IPD_bus[95:64];
    end else if (ID_flush || depart) begin
      ipd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ipd_valid_q <= 1'b0;
      pc_q        <= 32'h0;
      pred_pc_q   <= 32'h0;
    end else begin
      ipd_valid_q <= ipd_valid_d;
      pc_q        <= pc_d;
      pred_pc_q   <= pred_pc_d;
    end
  end

  ipd_inst_hold #(
    .RESET_INST(RESET_INST)
  ) u_hold (
    .clk    (clk),
    .reset  (reset),
    .capture(capture),
    .depart (depart),
    .flush  (ID_flush),
    .valid  (ipd_valid_q),
    .rdata  (inst_ram_rdata),
    .inst   (inst)
  );

  assign IPD_to_ID_valid = ipd_valid_q & ipd_ready_go & ~ID_flush;

`ifdef IPD_PREDECODE_EN
  predec_t pd;
  assign pd            = predecode(inst);
  assign IPD_to_ID_bus = {pd, pred_pc_q, pc_q, inst};
`else
  assign IPD_to_ID_bus = {pred_pc_q, pc_q, inst};
`endif

endmodule

// File: tb/tb_ipd_stage.sv
// Scoreboard bench for ipd_stage: directed vectors, monitor on ID side.
// Build with +define+IPD_PREDECODE_EN to also check the predecode bits.
module tb_ipd_stage;
  import ipd_stage_pkg::*;

  logic                        clk;
  logic                        reset;
  logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus;
  logic                        IF_to_IPD_valid;
  logic                        IPD_allow_in;
  logic [31:0]                 inst_ram_rdata;
  logic                        ID_flush;
  logic [IPD_TO_ID_BUS_WD-1:0] IPD_to_ID_bus;
  logic                        IPD_to_ID_valid;
  logic                        ID_allow_in;

  ipd_stage dut (
    .clk            (clk),
    .reset          (reset),
    .IF_to_IPD_bus  (IF_to_IPD_bus),
    .IF_to_IPD_valid(IF_to_IPD_valid),
    .IPD_allow_in   (IPD_allow_in),
    .inst_ram_rdata (inst_ram_rdata),
    .ID_flush       (ID_flush),
    .IPD_to_ID_bus  (IPD_to_ID_bus),
    .IPD_to_ID_valid(IPD_to_ID_valid),
    .ID_allow_in    (ID_allow_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] bus;
    logic [3:0]  pd;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pred, input logic [31:0] pc,
                      input logic [31:0] inst, input logic [3:0] pd);
    exp_t e;
    e.bus = {pred, pc, inst};
    e.pd  = pd;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] pred, input logic [31:0] pc);
    IF_to_IPD_bus   = {pred, pc, 32'h0};
    IF_to_IPD_valid = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && IPD_to_ID_valid && ID_allow_in) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stale_out: got pc %0h with nothing expected",
                 IPD_to_ID_bus[63:32]);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_bus", 128'(IPD_to_ID_bus[95:0]), 128'(e.bus));
`ifdef IPD_PREDECODE_EN
        chk("predec", 128'(IPD_to_ID_bus[99:96]), 128'(e.pd));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    IF_to_IPD_bus   = '0;
    IF_to_IPD_valid = 1'b0;
    inst_ram_rdata  = 32'h0;
    ID_flush        = 1'b0;
    ID_allow_in     = 1'b1;

    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      chk("rst_valid", 128'(IPD_to_ID_valid), 128'(0));
      chk("rst_allow", 128'(IPD_allow_in), 128'(1));
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 128'(IPD_to_ID_valid), 128'(0));
    chk("post_rst_allow", 128'(IPD_allow_in), 128'(1));

    // single entry, no stall
    cyc();
    issue(32'h1c000004, 32'h1c000000);
    push(32'h1c000004, 32'h1c000000, 32'h02800c21, 4'b0000);
    cyc();
    IF_to_IPD_valid = 1'b0;
    inst_ram_rdata  = 32'h02800c21;
    @(negedge clk);
    chk("cap_valid", 128'(IPD_to_ID_valid), 128'(1));

    // stall for 3 cycles, RAM output changes mid-stall
    cyc();
    issue(32'h1c000014, 32'h1c000010);
    push(32'h1c000014, 32'h1c000010, 32'h02800c21, 4'b0000);
    ID_allow_in = 1'b0;
    cyc();
    IF_to_IPD_valid = 1'b0;
    inst_ram_rdata  = 32'h02800c21;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_allow", 128'(IPD_allow_in), 128'(0));
      chk("stall_valid", 128'(IPD_to_ID_valid), 128'(1));
      chk("stall_inst", 128'(IPD_to_ID_bus[31:0]), 128'(32'h02800c21));
      cyc();
      if (i == 0) inst_ram_rdata = 32'hdeadbeef;
    end
    ID_allow_in = 1'b1;
    @(negedge clk);
    chk("release_allow", 128'(IPD_allow_in), 128'(1));

    // back-to-back: depart and capture in one cycle
    cyc();
    issue(32'h1c000024, 32'h1c000020);
    push(32'h1c000024, 32'h1c000020, 32'h58000000, 4'b0010);
    cyc();
    inst_ram_rdata = 32'h58000000;
    issue(32'h1c000028, 32'h1c000024);
    push(32'h1c000028, 32'h1c000024, 32'h54000400, 4'b0101);
    @(negedge clk);
    chk("b2b_allow", 128'(IPD_allow_in), 128'(1));
    cyc();
    IF_to_IPD_valid = 1'b0;
    inst_ram_rdata  = 32'h54000400;
    @(negedge clk);

    // flush with a capture of the redirect target
    cyc();
    ID_allow_in = 1'b0;
    issue(32'h1c000034, 32'h1c000030);
    push(32'h1c000034, 32'h1c000030, 32'h11111111, 4'b0000);
    cyc();
    inst_ram_rdata = 32'h11111111;
    ID_flush       = 1'b1;
    issue(32'h1c000104, 32'h1c000100);
    void'(sb.pop_back());
    push(32'h1c000104, 32'h1c000100, 32'h4c000020, 4'b1000);
    @(negedge clk);
    chk("flush_cap_valid", 128'(IPD_to_ID_valid), 128'(0));
    chk("flush_cap_allow", 128'(IPD_allow_in), 128'(1));
    cyc();
    ID_flush        = 1'b0;
    IF_to_IPD_valid = 1'b0;
    ID_allow_in     = 1'b1;
    inst_ram_rdata  = 32'h4c000020;
    @(negedge clk);
    chk("redirect_pc", 128'(IPD_to_ID_bus[63:32]), 128'(32'h1c000100));

    // flush with no capture
    cyc();
    ID_allow_in = 1'b0;
    issue(32'h1c000204, 32'h1c000200);
    push(32'h1c000204, 32'h1c000200, 32'h22222222, 4'b0000);
    cyc();
    IF_to_IPD_valid = 1'b0;
    inst_ram_rdata  = 32'h22222222;
    cyc();
    ID_flush = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    chk("flush_valid", 128'(IPD_to_ID_valid), 128'(0));
    cyc();
    ID_flush       = 1'b0;
    ID_allow_in    = 1'b1;
    inst_ram_rdata = 32'h33333333;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_flush_valid", 128'(IPD_to_ID_valid), 128'(0));
      cyc();
    end

    // reset in the middle of a stall
    ID_allow_in = 1'b0;
    issue(32'h1c000304, 32'h1c000300);
    push(32'h1c000304, 32'h1c000300, 32'h44444444, 4'b0000);
    cyc();
    IF_to_IPD_valid = 1'b0;
    inst_ram_rdata  = 32'h44444444;
    cyc();
    reset = 1'b1;
    sb.delete();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 128'(IPD_to_ID_valid), 128'(0));
    chk("mid_rst_allow", 128'(IPD_allow_in), 128'(1));
    cyc();
    issue(32'h1c000404, 32'h1c000400);
    push(32'h1c000404, 32'h1c000400, 32'h55555555, 4'b0000);
    cyc();
    IF_to_IPD_valid = 1'b0;
    inst_ram_rdata  = 32'h55555555;
    cyc();
    inst_ram_rdata = 32'h66666666;
    ID_allow_in    = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
